// File: rtl/bsg_fifo_credit_pkg.sv
// Shared types and sizing helpers for the credit-based FIFO egress block.
package bsg_fifo_credit_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    IDLE = 2'd2
  } state_e;

  // Counter must hold every value from 0 up to and including the full credit count.
  function automatic int credit_cnt_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  localparam int default_credits_lp   = 4;
  localparam int default_cnt_width_lp = credit_cnt_width(default_credits_lp);

endpackage

// File: rtl/bsg_credit_counter.sv
// Saturating up/down credit counter that reloads to max_p and flags returns beyond max_p.
module bsg_credit_counter #(
  parameter int max_p   = 4,
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [width_p-1:0] cnt_o,
  output logic               overflow_o
);

  localparam logic [width_p-1:0] max_lp = width_p'(max_p);

  // A lone return at full count is a protocol error: hold the count, latch the flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_o      <= max_lp;
      overflow_o <= 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt_o == max_lp) overflow_o <= 1'b1;
      else                 cnt_o      <= cnt_o + 1'b1;
    end else if (dec_i && !inc_i && (cnt_o != '0)) begin
      cnt_o <= cnt_o - 1'b1;
    end
  end

endmodule

// File: rtl/bsg_fifo_credit_egress.sv
// Pops a valid/yumi FIFO onto a registered credit-flow-controlled link, with drain/quiesce.
module bsg_fifo_credit_egress
  import bsg_fifo_credit_pkg::*;
#(
  parameter  int width_p      = 8,
  parameter  int credits_p    = 4,
  localparam int cnt_width_lp = credit_cnt_width(credits_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    yumi_o,
  output logic                    link_v_o,
  output logic [width_p-1:0]      link_data_o,
  input  logic                    credit_i,
  input  logic                    drain_i,
  output logic                    idle_o,
  output logic [cnt_width_lp-1:0] credits_o,
  output logic                    credit_err_o
);

  localparam logic [cnt_width_lp-1:0] full_lp = cnt_width_lp'(credits_p);

  logic [1:0] rst_sync_r;
  logic       rst_n;
  state_e     state_r;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_r <= '0;
    else            rst_sync_r <= {rst_sync_r[0], 1'b1};
  end

  assign rst_n = rst_sync_r[1];

  // Drain blocks pops in the same cycle it is raised, before the FSM leaves RUN.
  assign yumi_o = v_i & (credits_o != '0) & (state_r == RUN) & ~drain_i & rst_n;

  bsg_credit_counter #(
    .max_p   (credits_p),
    .width_p (cnt_width_lp)
  ) credit_counter (
    .clk_i      (clk_i),
    .reset_n_i  (rst_n),
    .inc_i      (credit_i),
    .dec_i      (yumi_o),
    .cnt_o      (credits_o),
    .overflow_o (credit_err_o)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RUN;
      idle_o  <= 1'b0;
    end else begin
      unique case (state_r)
        RUN: begin
          if (drain_i) state_r <= HALT;
        end
        HALT: begin
          if (!drain_i) begin
            state_r <= RUN;
          end else if ((credits_o == full_lp) && !link_v_o) begin
            state_r <= IDLE;
            idle_o  <= 1'b1;
          end
        end
        IDLE: begin
          if (!drain_i) begin
            state_r <= RUN;
            idle_o  <= 1'b0;
          end
        end
        default: begin
          state_r <= RUN;
          idle_o  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      link_v_o    <= 1'b0;
      link_data_o <= '0;
    end else begin
      link_v_o <= yumi_o;
      if (yumi_o) link_data_o <= data_i;
    end
  end

endmodule
